// File: rtl/mem_bridge.sv
// Native CPU memory bus to single-port synchronous RAM bridge.
// Adds optional wait states, range checking, a sticky error flag and a transaction counter.
module mem_bridge #(
  parameter int ADDR_BITS   = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic [3:0]           ram_wen,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic                 bus_err,
  output logic [15:0]          txn_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [ADDR_BITS-1:0] req_word;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wstrb;
  logic [3:0]           wait_cnt;
  logic                 out_of_range;
  logic                 accept;

  // The fetch qualifier carries no meaning for a plain RAM.
  logic unused_instr;
  assign unused_instr = mem_instr;

  // Any address bit above the RAM's byte range makes the request out of range.
  assign out_of_range = (mem_addr >> (ADDR_BITS + 2)) != '0;
  assign accept       = (state == IDLE) && mem_valid;

  assign ram_addr  = req_word;
  assign ram_wdata = req_wdata;

  always_comb begin
    state_n = state;
    ram_wen = '0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (out_of_range)         state_n = RESP;
          else if (WAIT_STATES > 0) state_n = WAIT;
          else                      state_n = ACCESS;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) state_n = ACCESS;
      end
      ACCESS: begin
        ram_wen = req_wstrb;
        state_n = (req_wstrb != '0) ? RESP : CAPTURE;
      end
      CAPTURE: state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
    end else begin
      state     <= state_n;
      mem_ready <= (state_n == RESP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_word  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else if (accept) begin
      req_word  <= mem_addr[ADDR_BITS+1:2];
      req_wdata <= mem_wdata;
      req_wstrb <= mem_wstrb;
    end
  end

  // Loaded with W-1 so that the cycle reading zero is the last of exactly W wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (accept && !out_of_range && (WAIT_STATES > 0)) begin
      wait_cnt <= 4'(WAIT_STATES - 1);
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (accept && out_of_range) begin
        mem_rdata <= '0;
        bus_err   <= 1'b1;
      end else if (state == CAPTURE) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_count <= '0;
    end else if (state == RESP) begin
      txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomised scoreboard bench for mem_bridge: one instance without and one with wait states,
// each attached to a byte-writable RAM model with one cycle of read latency.
module tb_mem_bridge;

  localparam int AB = 5;
  localparam int NW = 32;
  localparam int W0 = 0;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_clr = 1'b1;

  logic              mem_valid_a [2];
  logic              mem_instr_a [2];
  logic [31:0]       mem_addr_a  [2];
  logic [31:0]       mem_wdata_a [2];
  logic [3:0]        mem_wstrb_a [2];
  logic              mem_ready_a [2];
  logic [31:0]       mem_rdata_a [2];
  logic [3:0]        ram_wen_a   [2];
  logic [AB-1:0]     ram_addr_a  [2];
  logic [31:0]       ram_wdata_a [2];
  logic [31:0]       ram_rdata_a [2];
  logic              bus_err_a   [2];
  logic [15:0]       txn_a       [2];

  mem_bridge #(.ADDR_BITS(AB), .WAIT_STATES(W0)) dut0 (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid_a[0]), .mem_instr(mem_instr_a[0]), .mem_addr(mem_addr_a[0]),
    .mem_wdata(mem_wdata_a[0]), .mem_wstrb(mem_wstrb_a[0]), .mem_ready(mem_ready_a[0]),
    .mem_rdata(mem_rdata_a[0]), .ram_wen(ram_wen_a[0]), .ram_addr(ram_addr_a[0]),
    .ram_wdata(ram_wdata_a[0]), .ram_rdata(ram_rdata_a[0]), .bus_err(bus_err_a[0]),
    .txn_count(txn_a[0])
  );

  mem_bridge #(.ADDR_BITS(AB), .WAIT_STATES(W1)) dut1 (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid_a[1]), .mem_instr(mem_instr_a[1]), .mem_addr(mem_addr_a[1]),
    .mem_wdata(mem_wdata_a[1]), .mem_wstrb(mem_wstrb_a[1]), .mem_ready(mem_ready_a[1]),
    .mem_rdata(mem_rdata_a[1]), .ram_wen(ram_wen_a[1]), .ram_addr(ram_addr_a[1]),
    .ram_wdata(ram_wdata_a[1]), .ram_rdata(ram_rdata_a[1]), .bus_err(bus_err_a[1]),
    .txn_count(txn_a[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models attached to the two bridges.
  logic [31:0] ram_m [2][NW];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_clr) begin
        for (int w = 0; w < NW; w++) ram_m[i][w] <= '0;
        ram_rdata_a[i] <= '0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_wen_a[i][b]) ram_m[i][ram_addr_a[i]][8*b +: 8] <= ram_wdata_a[i][8*b +: 8];
        ram_rdata_a[i] <= ram_m[i][ram_addr_a[i]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [2][NW];
  logic [31:0] last_rd [2];
  logic        exp_err [2];
  logic [15:0] exp_txn [2];
  int          wen_cnt [2];

  typedef struct {
    int          idx;
    int          issue;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        oor;
    int          widx;
  } item_t;

  item_t exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic int wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks RAM strobes against the pending request and pops on every completion.
  always @(negedge clk) begin
    item_t it;
    for (int i = 0; i < 2; i++) begin
      if (ram_wen_a[i] != 4'h0) begin
        if (exp_q.size() == 0 || exp_q[0].idx != i || exp_q[0].oor || exp_q[0].wstrb == 4'h0) begin
          chk("wen_spurious", 32'(ram_wen_a[i]), 32'h0);
        end else begin
          chk("wen_value", 32'(ram_wen_a[i]), 32'(exp_q[0].wstrb));
          chk("wen_cycle", cyc, exp_q[0].issue + wait_of(i) + 1);
          chk("ram_addr", 32'(ram_addr_a[i]), exp_q[0].widx);
          chk("ram_wdata", ram_wdata_a[i], exp_q[0].wdata);
          wen_cnt[i]++;
        end
      end
      if (mem_ready_a[i]) begin
        if (exp_q.size() == 0 || exp_q[0].idx != i) begin
          chk("ready_spurious", 32'(mem_ready_a[i]), 32'h0);
        end else begin
          it = exp_q.pop_front();
          chk("latency", cyc - it.issue, it.lat);
          chk("rdata", mem_rdata_a[i], it.rdata);
          chk("bus_err", 32'(bus_err_a[i]), 32'(exp_err[i]));
          chk("txn_count", 32'(txn_a[i]), 32'(exp_txn[i]));
          chk("wen_cycles", wen_cnt[i], (!it.oor && it.wstrb != 4'h0) ? 1 : 0);
          exp_txn[i]++;
        end
      end
    end
  end

  // Called just after a negedge with the bridge idle; returns just after a negedge with it idle again.
  task automatic drive(input int i, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit drop);
    item_t it;
    bit seen;
    seen     = 1'b0;
    it.idx   = i;
    it.issue = cyc;
    it.wdata = wdata;
    it.wstrb = wstrb;
    it.oor   = (addr >= 32'(4 * NW));
    it.widx  = int'((addr / 4) % NW);
    if (it.oor) begin
      it.lat     = 1;
      it.rdata   = '0;
      exp_err[i] = 1'b1;
      last_rd[i] = '0;
    end else if (wstrb == 4'h0) begin
      it.lat     = 3 + wait_of(i);
      it.rdata   = ref_mem[i][it.widx];
      last_rd[i] = it.rdata;
    end else begin
      it.lat   = 2 + wait_of(i);
      it.rdata = last_rd[i];
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[i][it.widx][8*b +: 8] = wdata[8*b +: 8];
    end
    wen_cnt[i] = 0;
    exp_q.push_back(it);
    mem_valid_a[i] = 1'b1;
    mem_addr_a[i]  = addr;
    mem_wdata_a[i] = wdata;
    mem_wstrb_a[i] = wstrb;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      if (mem_ready_a[i]) begin
        seen = 1'b1;
      end else if (drop && n == 1) begin
        mem_valid_a[i] = 1'b0;
      end else if (!drop && n == 0) begin
        mem_addr_a[i]  = $urandom;
        mem_wdata_a[i] = $urandom;
        mem_wstrb_a[i] = 4'($urandom_range(0, 15));
      end
    end
    mem_valid_a[i] = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no mem_ready expected one within 64 cycles (inst %0d)", i);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_txn(input int i);
    logic [31:0] addr;
    logic [3:0]  wstrb;
    bit          drop;
    if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_0080;
    else                           addr = 32'($urandom_range(0, 4 * NW - 1));
    wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    drop  = ($urandom_range(0, 4) == 0);
    drive(i, addr, $urandom, wstrb, drop);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      mem_valid_a[i] = 1'b0;
      mem_instr_a[i] = 1'b0;
      mem_addr_a[i]  = '0;
      mem_wdata_a[i] = '0;
      mem_wstrb_a[i] = '0;
      last_rd[i]     = '0;
      exp_err[i]     = 1'b0;
      exp_txn[i]     = '0;
      wen_cnt[i]     = 0;
      for (int w = 0; w < NW; w++) ref_mem[i][w] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(mem_ready_a[i]), 32'h0);
      chk("rst_rdata", mem_rdata_a[i], 32'h0);
      chk("rst_wen", 32'(ram_wen_a[i]), 32'h0);
      chk("rst_bus_err", 32'(bus_err_a[i]), 32'h0);
      chk("rst_txn", 32'(txn_a[i]), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr_a[i]), 32'h0);
    end
    reset   = 1'b0;
    ram_clr = 1'b0;

    // Zero wait states: directed cases, first one issued on the first edge after reset.
    drive(0, 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("txn_after_first", 32'(txn_a[0]), 32'h1);
    drive(0, 32'h08, 32'h0, 4'h0, 1'b0);
    drive(0, 32'h0C, 32'h1122_3344, 4'h3, 1'b0);
    drive(0, 32'h0E, 32'h0, 4'h0, 1'b0);
    drive(0, 32'h80, 32'h0, 4'h0, 1'b0);
    chk("oor_sticky", 32'(bus_err_a[0]), 32'h1);
    drive(0, 32'h08, 32'h0, 4'h0, 1'b0);
    drive(0, 32'h1000_0004, 32'h5555_AAAA, 4'hF, 1'b0);
    repeat (40) rand_txn(0);

    // Three wait states, including requests whose valid drops mid-flight.
    drive(1, 32'h10, 32'hA5A5_5A5A, 4'hF, 1'b0);
    drive(1, 32'h10, 32'h0, 4'h0, 1'b0);
    drive(1, 32'h14, 32'h1234_5678, 4'hC, 1'b1);
    drive(1, 32'h14, 32'h0, 4'h0, 1'b1);
    repeat (40) rand_txn(1);

    // Reset during the ACCESS cycle of a write aborts it.
    begin
      item_t it;
      it.idx = 0; it.issue = cyc; it.lat = 2; it.rdata = last_rd[0];
      it.wdata = 32'hCAFE_F00D; it.wstrb = 4'hF; it.oor = 1'b0; it.widx = 5;
      wen_cnt[0] = 0;
      exp_q.push_back(it);
      mem_valid_a[0] = 1'b1;
      mem_addr_a[0]  = 32'h14;
      mem_wdata_a[0] = 32'hCAFE_F00D;
      mem_wstrb_a[0] = 4'hF;
      @(negedge clk);
      #1 reset = 1'b1;
      #1 chk("abort_wen", 32'(ram_wen_a[0]), 32'h0);
      exp_q.delete();
      mem_valid_a[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        exp_txn[i] = '0;
        exp_err[i] = 1'b0;
        last_rd[i] = '0;
      end
      repeat (2) begin
        @(negedge clk);
        chk("abort_no_ready", 32'(mem_ready_a[0]), 32'h0);
      end
      reset = 1'b0;
      chk("abort_bus_err", 32'(bus_err_a[0]), 32'h0);
      drive(0, 32'h14, 32'h0, 4'h0, 1'b0);
    end

    // Counter wrap from 0xFFFF.
    force dut0.txn_count = 16'hFFFF;
    @(negedge clk);
    release dut0.txn_count;
    exp_txn[0] = 16'hFFFF;
    drive(0, 32'h04, 32'h0, 4'h0, 1'b0);
    chk("txn_wrap", 32'(txn_a[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_BITS, default 5: word-address width of the attached synchronous RAM (RAM holds 2**ADDR_BITS 32-bit words).
REQ-002 Parameter WAIT_STATES, default 0, legal range 0..15: extra idle cycles inserted before every RAM access.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_valid  input  1  CPU native-bus request valid.
REQ-006 mem_instr  input  1  CPU fetch qualifier; accepted and unused.
REQ-007 mem_addr  input  32  CPU byte address.
REQ-008 mem_wdata  input  32  CPU write data.
REQ-009 mem_wstrb  input  4  CPU byte strobes; 0 = read.
REQ-010 mem_ready  output  1  registered one-cycle completion pulse to the CPU.
REQ-011 mem_rdata  output  32  registered read data, valid while mem_ready=1.
REQ-012 ram_wen  output  4  byte write enables to the RAM.
REQ-013 ram_addr  output  ADDR_BITS  RAM word address.
REQ-014 ram_wdata  output  32  RAM write data.
REQ-015 ram_rdata  input  32  RAM read data, one-cycle registered latency after ram_addr is sampled.
REQ-016 bus_err  output  1  sticky flag: an out-of-range access occurred.
REQ-017 txn_count  output  16  count of completed transactions.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, ACCESS, CAPTURE and RESP.
REQ-019 In IDLE with mem_valid=1, the block SHALL latch mem_addr, mem_wdata and mem_wstrb into request registers.
REQ-020 Out-of-range test: a request is out of range when mem_addr[31:ADDR_BITS+2] != 0; bits [1:0] are ignored.
REQ-021 Out-of-range request: IDLE->RESP directly; no RAM write; mem_rdata=0; bus_err set to 1 on the IDLE->RESP edge.
REQ-022 In-range request: IDLE->WAIT when WAIT_STATES>0, else IDLE->ACCESS.
REQ-023 WAIT: a 4-bit counter loaded with WAIT_STATES-1 on entry SHALL decrement each cycle; WAIT->ACCESS when it reads 0, giving exactly WAIT_STATES WAIT cycles.
REQ-024 ACCESS lasts one cycle: ram_wen = latched wstrb; ram_addr and ram_wdata driven from the request registers.
REQ-025 ACCESS is followed by RESP for a write (wstrb!=0) and by CAPTURE for a read (wstrb==0).
REQ-026 CAPTURE lasts one cycle: mem_rdata registered from ram_rdata; CAPTURE->RESP.
REQ-027 RESP lasts one cycle with mem_ready=1, then RESP->IDLE; mem_valid is ignored during RESP.
REQ-028 ram_wen SHALL be 4'b0000 in every state other than ACCESS.
REQ-029 ram_addr = request address [ADDR_BITS+1:2] in all states; ram_wdata = latched wdata in all states.
REQ-030 Latency from the IDLE cycle sampling mem_valid to mem_ready=1, with W=WAIT_STATES: read 3+W cycles; write 2+W cycles; out-of-range 1 cycle.
REQ-031 mem_rdata SHALL hold its value outside RESP until the next CAPTURE or out-of-range RESP; it is 0 after an out-of-range write as well.
REQ-032 If mem_valid drops mid-transaction, the transaction SHALL still complete, including the write and the mem_ready pulse.
REQ-033 Request registers SHALL NOT change outside IDLE.
REQ-034 txn_count SHALL increment by 1 on each RESP cycle, including out-of-range RESP cycles, and wraps from 0xFFFF to 0x0000.
REQ-035 bus_err, once set, SHALL stay set until reset.

Reset
REQ-036 While reset=1, asynchronously: state=IDLE, mem_ready=0, mem_rdata=0, ram_wen=0, request registers=0, wait counter=0, bus_err=0, txn_count=0.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction with no further RAM write, and no mem_ready pulse occurs for it.
REQ-038 The first request SHALL be accepted on the first rising edge with reset=0.

Verification
REQ-039 W=0; write addr 0x08, wdata 0xDEADBEEF, wstrb 0xF -> ram_wen=0xF, ram_addr=2 in cycle 1; mem_ready=1 in cycle 2; txn_count=1.
REQ-040 W=0; read addr 0x08 after that write, RAM model returns 0xDEADBEEF -> mem_ready=1 in cycle 3 with mem_rdata=0xDEADBEEF.
REQ-041 W=0; write addr 0x0C, wdata 0x11223344, wstrb 0x3 -> ram_wen=0x3 for exactly one cycle; readback of addr 0x0C shows only bytes [15:0]=0x3344 changed.
REQ-042 Read addr 0x00000080 (ADDR_BITS=5) -> mem_ready=1 in cycle 1, mem_rdata=0, bus_err=1, ram_wen stays 0 throughout.
REQ-043 W=3; read -> mem_ready in cycle 6; write -> mem_ready in cycle 5; mem_valid dropped in cycle 2 -> transaction still completes.
REQ-044 Reset asserted in ACCESS of a write -> ram_wen=0 immediately, no mem_ready pulse; txn_count preset to 0xFFFF then one transaction -> txn_count=0x0000.
